// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM encoding, frame constants, baud math.
// Used by both transmitter and receiver so their bit timing matches.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_t;

  localparam int   DATA_BITS  = 8;
  localparam logic STOP_LEVEL = 1'b1;

  function automatic int clks_per_bit(
    input int clk_freq,
    input int baud
  );
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_byte_rx_if.sv
// Receiver-side bundle: serial line in, byte/strobes/busy out.
// master = receiver, slave = line driver plus byte consumer.
interface uart_byte_rx_if;

  logic       rx;
  logic [7:0] data;
  logic       rx_done;
  logic       frame_err;
  logic       busy;

  modport master (
    input  rx,
    output data,
    output rx_done,
    output frame_err,
    output busy
  );

  modport slave (
    output rx,
    input  data,
    input  rx_done,
    input  frame_err,
    input  busy
  );

endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer plus edge register for the serial line.
// Ports: clk, rst_n, rx in; rx_s (synced level), fall (high->low) out.
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic rx,
  output logic rx_s,
  output logic fall
);

  logic s1;
  logic s2;
  logic s3;

  // Reset to idle-high so no false edge appears after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      s3 <= 1'b1;
    end else begin
      s1 <= rx;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rx_s = s2;
  assign fall = s3 & ~s2;

endmodule

// File: rtl/uart_byte_rx.sv
// 8N1 UART receiver with mid-bit sampling and start-glitch reject.
// Ports: clk, rst_n, bus (rx in; data, rx_done, frame_err, busy out).
module uart_byte_rx #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 9600
) (
  input  logic           clk,
  input  logic           rst_n,
  uart_byte_rx_if.master bus
);

  import uart_pkg::*;

  localparam int BIT_CNT  = clks_per_bit(CLK_FREQ, BAUD);
  localparam int HALF_CNT = BIT_CNT / 2;
  localparam int CW       = $clog2(BIT_CNT);

  localparam logic [CW-1:0] BIT_END  = CW'(BIT_CNT - 1);
  localparam logic [CW-1:0] HALF_END = CW'(HALF_CNT - 1);
  localparam logic [2:0]    LAST_BIT = 3'(DATA_BITS - 1);

  uart_state_t   state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic [7:0]    data;
  logic          rx_done;
  logic          frame_err;
  logic          rx_s;
  logic          fall;

  uart_rx_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .rx    (bus.rx),
    .rx_s  (rx_s),
    .fall  (fall)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      data      <= '0;
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
      unique case (state)
        IDLE: begin
          cnt <= '0;
          if (fall) state <= START;
        end
        START: begin
          if (cnt == HALF_END) begin
            cnt     <= '0;
            bit_idx <= '0;
            // Line back high at mid-start: treat as a glitch.
            state   <= rx_s ? IDLE : DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == BIT_END) begin
            cnt            <= '0;
            shreg[bit_idx] <= rx_s;
            bit_idx        <= bit_idx + 1'b1;
            if (bit_idx == LAST_BIT) state <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == BIT_END) begin
            cnt   <= '0;
            // Leave at mid-stop so a following start edge is not missed.
            state <= IDLE;
            if (rx_s == STOP_LEVEL) begin
              data    <= shreg;
              rx_done <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.data      = data;
  assign bus.rx_done   = rx_done;
  assign bus.frame_err = frame_err;
  assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_uart_byte_rx.sv
// Directed bench for uart_byte_rx at 16 clk/bit.
// Monitors strobes on the falling edge and checks hand-computed values.
module tb_uart_byte_rx;

  localparam int CF = 160;
  localparam int BD = 10;
  localparam int P  = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  uart_byte_rx_if bus ();

  uart_byte_rx #(
    .CLK_FREQ (CF),
    .BAUD     (BD)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  int cyc      = 0;
  int done_n   = 0;
  int ferr_n   = 0;
  int both_n   = 0;
  int done_cyc = 0;
  logic [7:0] rxq[$];

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (bus.rx_done) begin
      done_n++;
      done_cyc = cyc;
      rxq.push_back(bus.data);
    end
    if (bus.frame_err) ferr_n++;
    if (bus.rx_done && bus.frame_err) both_n++;
  end

  task automatic idle(input int n);
    bus.rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send(
    input logic [7:0] b,
    input int         p,
    input logic       stop
  );
    bus.rx = 1'b0;
    repeat (p) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      bus.rx = b[i];
      repeat (p) @(negedge clk);
    end
    bus.rx = stop;
    repeat (p) @(negedge clk);
    bus.rx = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    int f0;
    int s;
    int lat;
    logic [7:0] q0;
    logic [7:0] q1;
    logic [7:0] v;

    bus.rx = 1'b1;
    rst_n  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_data", bus.data, 8'h00);
    check("rst_done", bus.rx_done, 1'b0);
    check("rst_ferr", bus.frame_err, 1'b0);
    check("rst_busy", bus.busy, 1'b0);
    rst_n = 1'b1;
    idle(10);

    // single frame, nominal rate
    d0 = done_n;
    f0 = ferr_n;
    s  = cyc;
    send(8'h55, P, 1'b1);
    idle(2 * P);
    lat = done_cyc - s - 1;
    check("t1_done", done_n - d0, 1);
    check("t1_data", bus.data, 8'h55);
    check("t1_ferr", ferr_n - f0, 0);
    check("t1_lat", (lat >= 154 && lat <= 156), 1);

    // back-to-back, no idle between frames
    d0 = done_n;
    f0 = ferr_n;
    rxq.delete();
    send(8'hA5, P, 1'b1);
    send(8'h3C, P, 1'b1);
    idle(2 * P);
    q0 = (rxq.size() > 0) ? rxq[0] : 8'h00;
    q1 = (rxq.size() > 1) ? rxq[1] : 8'h00;
    check("t2_done", done_n - d0, 2);
    check("t2_byte0", q0, 8'hA5);
    check("t2_byte1", q1, 8'h3C);
    check("t2_ferr", ferr_n - f0, 0);

    // 5-cycle start glitch
    d0 = done_n;
    f0 = ferr_n;
    bus.rx = 1'b0;
    repeat (5) @(negedge clk);
    check("t3_busy_in", bus.busy, 1'b1);
    idle(12);
    check("t3_busy_out", bus.busy, 1'b0);
    check("t3_done", done_n - d0, 0);
    check("t3_ferr", ferr_n - f0, 0);
    idle(P);
    send(8'hFF, P, 1'b1);
    idle(2 * P);
    check("t3_data", bus.data, 8'hFF);
    check("t3_done2", done_n - d0, 1);

    // stop bit low
    d0 = done_n;
    f0 = ferr_n;
    send(8'h81, P, 1'b0);
    idle(2 * P);
    check("t4_ferr", ferr_n - f0, 1);
    check("t4_done", done_n - d0, 0);
    check("t4_data", bus.data, 8'hFF);

    // break: line held low
    d0 = done_n;
    f0 = ferr_n;
    bus.rx = 1'b0;
    repeat (20 * P) @(negedge clk);
    check("t5_ferr", ferr_n - f0, 1);
    check("t5_done", done_n - d0, 0);
    check("t5_busy", bus.busy, 1'b0);
    idle(2 * P);
    check("t5_ferr2", ferr_n - f0, 1);

    // reset during data bit 4
    d0 = done_n;
    f0 = ferr_n;
    v  = 8'hC3;
    bus.rx = 1'b0;
    repeat (P) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      bus.rx = v[i];
      repeat (P) @(negedge clk);
    end
    bus.rx = v[4];
    repeat (P / 2) @(negedge clk);
    check("t6_busy_pre", bus.busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("t6_data", bus.data, 8'h00);
    check("t6_busy", bus.busy, 1'b0);
    check("t6_done", bus.rx_done, 1'b0);
    check("t6_ferr", bus.frame_err, 1'b0);
    @(negedge clk);
    bus.rx = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    idle(2 * P);
    check("t6_busy_post", bus.busy, 1'b0);
    check("t6_nopulse", (done_n - d0) + (ferr_n - f0), 0);
    send(8'h12, P, 1'b1);
    idle(2 * P);
    check("t6_data2", bus.data, 8'h12);
    check("t6_done2", done_n - d0, 1);

    // rate skew: slow then fast sender
    d0 = done_n;
    f0 = ferr_n;
    send(8'h96, 17, 1'b1);
    idle(2 * P);
    check("t7_slow", bus.data, 8'h96);
    send(8'hD6, 15, 1'b1);
    idle(2 * P);
    check("t7_fast", bus.data, 8'hD6);
    check("t7_done", done_n - d0, 2);
    check("t7_ferr", ferr_n - f0, 0);

    check("excl", both_n, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
